apb4_gpio_ext: RTL

//  Second-generation APB4 GPIO: GPIO_NUM pins with per-pin direction, output, IO-function select,

---
 rtl/gpio_pkg.sv | 24 ++
 rtl/gpio_dbnc.sv | 37 +++
 rtl/apb4_gpio_ext.sv | 134 +++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets, interrupt type encoding and pin limit for apb4_gpio_ext
package gpio_pkg;
   localparam int GPIO_MAX = 32;
   localparam logic [3:0] GPIO_PADDIR    = 4'd0;
   localparam logic [3:0] GPIO_PADIN     = 4'd1;
   localparam logic [3:0] GPIO_PADOUT    = 4'd2;
   localparam logic [3:0] GPIO_OUTSET    = 4'd3;
   localparam logic [3:0] GPIO_OUTCLR    = 4'd4;
   localparam logic [3:0] GPIO_OUTTGL    = 4'd5;
   localparam logic [3:0] GPIO_INTEN     = 4'd6;
   localparam logic [3:0] GPIO_INTTYPE0  = 4'd7;
   localparam logic [3:0] GPIO_INTTYPE1  = 4'd8;
   localparam logic [3:0] GPIO_INTBOTH   = 4'd9;
   localparam logic [3:0] GPIO_INTSTATUS = 4'd10;
   localparam logic [3:0] GPIO_IOFCFG    = 4'd11;
   localparam logic [3:0] GPIO_DBNCEN    = 4'd12;
   localparam logic [3:0] GPIO_DBNCTHR   = 4'd13;
   typedef enum logic [1:0] {
      LEVEL_HIGH = 2'b00,
      LEVEL_LOW  = 2'b01,
      EDGE_RISE  = 2'b10,
      EDGE_FALL  = 2'b11
   } int_type_e;
endpackage

// File: rtl/gpio_dbnc.sv
// gpio_dbnc: single-pin debounce; the filtered value follows sync only after it differs for thr+1 cycles
module gpio_dbnc #(
   parameter int DBNC_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [DBNC_WIDTH-1:0] thr,
   input  logic                  sync,
   output logic                  filt
);
   logic [DBNC_WIDTH-1:0] cnt_q, cnt_d;
   logic                  filt_q, filt_d;

   // A count above a freshly lowered threshold restarts the run without updating filt
   always_comb begin
      filt_d = filt_q;
      cnt_d = '0;
      if (!en || thr == '0) filt_d = sync;
      else if (sync != filt_q) begin
         if (cnt_q == thr) filt_d = sync;
         else if (cnt_q < thr) cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         filt_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign filt = filt_q;
endmodule

// File: rtl/apb4_gpio_ext.sv
// apb4_gpio_ext: APB4 GPIO with input sync, per-pin debounce, typed interrupts,
// sticky W1C status and atomic set/clear/toggle output writes
module apb4_gpio_ext
   import gpio_pkg::*;
#(
   parameter int GPIO_NUM    = 32,
   parameter int SYNC_STAGES = 2,
   parameter int DBNC_WIDTH  = 8
) (
   input  logic                pclk,
   input  logic                presetn,
   input  logic [5:0]          paddr,
   input  logic                psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [GPIO_MAX-1:0] pwdata,
   output logic [GPIO_MAX-1:0] prdata,
   output logic                pready,
   output logic                pslverr,
   input  logic [GPIO_NUM-1:0] gpio_in_i,
   output logic [GPIO_NUM-1:0] gpio_in_sync_o,
   output logic [GPIO_NUM-1:0] gpio_out_o,
   output logic [GPIO_NUM-1:0] gpio_dir_o,
   output logic [GPIO_NUM-1:0] gpio_iof_o,
   output logic                irq_o
);
   logic [GPIO_NUM-1:0]   dir_q, dir_d, out_q, out_d, inten_q, inten_d, t0_q, t0_d, t1_q, t1_d;
   logic [GPIO_NUM-1:0]   both_q, both_d, stat_q, stat_d, iof_q, iof_d, den_q, den_d, prev_q, prev_d;
   logic [GPIO_NUM-1:0]   filt, rise, fall, evt, wd, clr;
   logic [DBNC_WIDTH-1:0] thr_q, thr_d;
   logic [GPIO_NUM-1:0]   sync_q [SYNC_STAGES];
   logic [GPIO_NUM-1:0]   sync_d [SYNC_STAGES];
   logic [3:0]            off;
   logic                  acc, wr, rd, unused_bits;
   int_type_e             ty;

   assign off = paddr[5:2];
   assign acc = psel & penable;
   assign wr = acc & pwrite;
   assign rd = acc & ~pwrite;
   assign wd = pwdata[GPIO_NUM-1:0];
   assign pready = 1'b1;
   assign pslverr = acc & ((off >= 4'd14) | (pwrite & (off == GPIO_PADIN)));
   assign unused_bits = ^{paddr[1:0], pwdata};
   assign rise = filt & ~prev_q;
   assign fall = ~filt & prev_q;

   for (genvar g = 0; g < GPIO_NUM; g++) begin : g_pin
      gpio_dbnc #(.DBNC_WIDTH(DBNC_WIDTH)) u_dbnc (
         .clk(pclk), .rst_n(presetn), .en(den_q[g]), .thr(thr_q),
         .sync(sync_q[SYNC_STAGES-1][g]), .filt(filt[g])
      );
   end

   always_comb begin
      {dir_d, out_d, inten_d, t0_d, t1_d} = {dir_q, out_q, inten_q, t0_q, t1_q};
      {both_d, iof_d, den_d, thr_d} = {both_q, iof_q, den_q, thr_q};
      clr = '0;
      if (wr) begin
         case (off)
            GPIO_PADDIR:    dir_d = wd;
            GPIO_PADOUT:    out_d = wd;
            GPIO_OUTSET:    out_d = out_q | wd;
            GPIO_OUTCLR:    out_d = out_q & ~wd;
            GPIO_OUTTGL:    out_d = out_q ^ wd;
            GPIO_INTEN:     inten_d = wd;
            GPIO_INTTYPE0:  t0_d = wd;
            GPIO_INTTYPE1:  t1_d = wd;
            GPIO_INTBOTH:   both_d = wd;
            GPIO_INTSTATUS: clr = wd;
            GPIO_IOFCFG:    iof_d = wd;
            GPIO_DBNCEN:    den_d = wd;
            GPIO_DBNCTHR:   thr_d = pwdata[DBNC_WIDTH-1:0];
            default:        ;
         endcase
      end
   end

   // A new event in the same cycle as its W1C wins over the clear
   always_comb begin
      evt = '0;
      ty = LEVEL_HIGH;
      for (int i = 0; i < GPIO_NUM; i++) begin
         ty = int_type_e'({t1_q[i], t0_q[i]});
         evt[i] = both_q[i] ? (rise[i] | fall[i]) :
                  ty == LEVEL_HIGH ? filt[i] : ty == LEVEL_LOW ? ~filt[i] :
                  ty == EDGE_RISE ? rise[i] : fall[i];
      end
      stat_d = (stat_q & ~clr) | (evt & inten_q);
      prev_d = filt;
      sync_d[0] = gpio_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
   end

   always_comb begin
      prdata = '0;
      if (rd) begin
         case (off)
            GPIO_PADDIR:    prdata = GPIO_MAX'(dir_q);
            GPIO_PADIN:     prdata = GPIO_MAX'(filt);
            GPIO_PADOUT:    prdata = GPIO_MAX'(out_q);
            GPIO_INTEN:     prdata = GPIO_MAX'(inten_q);
            GPIO_INTTYPE0:  prdata = GPIO_MAX'(t0_q);
            GPIO_INTTYPE1:  prdata = GPIO_MAX'(t1_q);
            GPIO_INTBOTH:   prdata = GPIO_MAX'(both_q);
            GPIO_INTSTATUS: prdata = GPIO_MAX'(stat_q);
            GPIO_IOFCFG:    prdata = GPIO_MAX'(iof_q);
            GPIO_DBNCEN:    prdata = GPIO_MAX'(den_q);
            GPIO_DBNCTHR:   prdata = GPIO_MAX'(thr_q);
            default:        prdata = '0;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         {dir_q, out_q, inten_q, t0_q, t1_q} <= '0;
         {both_q, stat_q, iof_q, den_q, prev_q} <= '0;
         thr_q <= '0;
         sync_q <= '{default: '0};
      end else begin
         {dir_q, out_q, inten_q, t0_q, t1_q} <= {dir_d, out_d, inten_d, t0_d, t1_d};
         {both_q, stat_q, iof_q, den_q, prev_q} <= {both_d, stat_d, iof_d, den_d, prev_d};
         thr_q <= thr_d;
         sync_q <= sync_d;
      end
   end

   assign gpio_in_sync_o = filt;
   assign gpio_out_o = out_q;
   assign gpio_dir_o = dir_q;
   assign gpio_iof_o = iof_q;
   assign irq_o = |(stat_q & inten_q);
endmodule
